// File: rtl/cnn_frame_feeder.sv
// Frame feeder for the CNN input stream: buffers one image from the host, replays it as
// data/valid beats once the CNN is idle, then returns its decision (or a timeout) to the host.
module cnn_frame_feeder #(
    parameter int unsigned IMG_PIXELS     = 784,
    parameter int unsigned ADDR_BIT       = 10,
    parameter int unsigned PIXEL_GAP      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TIMEOUT_BIT    = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [7:0] cnn_data,
    output logic       cnn_valid,
    input  logic       cnn_busy,
    input  logic [3:0] cnn_decision,
    input  logic       cnn_decision_valid,
    output logic [3:0] result_class,
    output logic       result_timeout,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       frame_busy
);

    typedef enum logic [2:0] {
        StLoad,
        StWaitIdle,
        StStream,
        StWaitResult,
        StHold
    } state_e;

    localparam logic [ADDR_BIT-1:0]    LastPix  = ADDR_BIT'(IMG_PIXELS - 1);
    localparam logic [TIMEOUT_BIT-1:0] LastTick = TIMEOUT_BIT'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_BIT-1:0] MaxTick  = {TIMEOUT_BIT{1'b1}};
    localparam logic [3:0]             GapLoad  = 4'(PIXEL_GAP);

    state_e r_state;
    state_e w_state_nxt;

    logic [7:0]             r_mem [IMG_PIXELS];
    logic [ADDR_BIT-1:0]    r_load_cnt;
    logic [ADDR_BIT-1:0]    r_str_cnt;
    logic [3:0]             r_gap_cnt;
    logic [TIMEOUT_BIT-1:0] r_to_cnt;
    logic [7:0]             r_cnn_data;
    logic                   r_cnn_valid;
    logic [3:0]             r_result_class;
    logic                   r_result_timeout;

    logic w_accept;
    logic w_load_last;
    logic w_issue;
    logic w_stream_last;
    logic w_decide;
    logic w_timeout;

    assign w_accept      = (r_state == StLoad) && host_valid;
    assign w_load_last   = w_accept && (r_load_cnt == LastPix);
    // A read is issued when the gap counter has run out; data appears one cycle later.
    assign w_issue       = (r_state == StStream) && (r_gap_cnt == 4'd0);
    assign w_stream_last = w_issue && (r_str_cnt == LastPix);
    assign w_decide      = (r_state == StWaitResult) && cnn_decision_valid;
    assign w_timeout     = (r_state == StWaitResult) && !cnn_decision_valid &&
                           (r_to_cnt == LastTick);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StLoad:       if (w_load_last) w_state_nxt = StWaitIdle;
            StWaitIdle:   if (!cnn_busy) w_state_nxt = StStream;
            StStream:     if (w_stream_last) w_state_nxt = StWaitResult;
            StWaitResult: if (w_decide || w_timeout) w_state_nxt = StHold;
            StHold:       if (result_ready) w_state_nxt = StLoad;
            default:      w_state_nxt = StLoad;
        endcase
    end

    always_comb begin
        host_ready   = (r_state == StLoad);
        result_valid = (r_state == StHold);
        frame_busy   = (r_state != StLoad);
    end

    // Frame buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_load_cnt] <= host_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_cnt <= '0;
            r_str_cnt  <= '0;
            r_gap_cnt  <= 4'd0;
            r_to_cnt   <= '0;
        end else begin
            if (w_load_last) begin
                r_load_cnt <= '0;
            end else if (w_accept) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end

            if (w_stream_last) begin
                r_str_cnt <= '0;
            end else if (w_issue) begin
                r_str_cnt <= r_str_cnt + 1'b1;
            end

            if (r_state != StStream) begin
                r_gap_cnt <= 4'd0;
            end else if (r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end else if (!w_stream_last) begin
                r_gap_cnt <= GapLoad;
            end

            if (w_stream_last) begin
                r_to_cnt <= '0;
            end else if ((r_state == StWaitResult) && (r_to_cnt != MaxTick)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnn_valid      <= 1'b0;
            r_cnn_data       <= 8'd0;
            r_result_class   <= 4'd0;
            r_result_timeout <= 1'b0;
        end else begin
            r_cnn_valid <= w_issue;
            if (w_issue) begin
                r_cnn_data <= r_mem[r_str_cnt];
            end
            // A decision on the final count takes priority over the timeout.
            if (w_decide) begin
                r_result_class   <= cnn_decision;
                r_result_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_result_class   <= 4'hF;
                r_result_timeout <= 1'b1;
            end
        end
    end

    assign cnn_data       = r_cnn_data;
    assign cnn_valid      = r_cnn_valid;
    assign result_class   = r_result_class;
    assign result_timeout = r_result_timeout;

endmodule
